// File: rtl/sakebi_crc32_arbiter.sv
// ============================================================================
// Module  : sakebi_crc32_arbiter
// Brief   : Round-robin frame arbiter sharing one CRC32 engine between two
//           byte-stream requesters, with short-frame padding and a timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sakebi_crc32_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MIN_BYTES      = 4
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESET,
  input  logic                  i_req0_TVALID,
  input  logic [DATA_WIDTH-1:0] i_req0_TDATA,
  input  logic                  i_req0_TLAST,
  output logic                  o_req0_TREADY,
  input  logic                  i_req1_TVALID,
  input  logic [DATA_WIDTH-1:0] i_req1_TDATA,
  input  logic                  i_req1_TLAST,
  output logic                  o_req1_TREADY,
  output logic                  o_crc_TVALID,
  output logic [DATA_WIDTH-1:0] o_crc_TDATA,
  input  logic                  i_crc_TVALID,
  input  logic [31:0]           i_crc_TDATA,
  output logic                  o_res_TVALID,
  output logic [31:0]           o_res_TDATA,
  output logic                  o_res_TID,
  output logic [15:0]           o_res_TLEN,
  output logic [2:0]            o_res_TUSER,
  input  logic                  i_res_TREADY
);

  localparam int unsigned     C_EW      = $clog2(MIN_BYTES + 2);
  localparam int unsigned     C_TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_EW-1:0] C_MIN     = C_EW'(MIN_BYTES);
  localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_PAD    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  rr_q, rr_d;
  logic [15:0]           len_q, len_d;
  logic [C_EW-1:0]       eng_q, eng_d;
  logic [C_TW-1:0]       to_q, to_d;
  logic [2:0]            flags_q, flags_d;
  logic                  crc_vld_q, crc_vld_d;
  logic [DATA_WIDTH-1:0] crc_data_q, crc_data_d;
  logic                  res_vld_q, res_vld_d;
  logic [31:0]           res_data_q, res_data_d;

  logic                  w_gvalid;
  logic                  w_glast;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic [C_EW-1:0]       w_eng_inc;

  assign w_gvalid  = grant_q ? i_req1_TVALID : i_req0_TVALID;
  assign w_glast   = grant_q ? i_req1_TLAST  : i_req0_TLAST;
  assign w_gdata   = grant_q ? i_req1_TDATA  : i_req0_TDATA;
  // eng_q counts bytes sent to the engine, saturating once the minimum is met
  assign w_eng_inc = eng_q + C_EW'(1);

  assign o_req0_TREADY = (state_q == S_STREAM) && !grant_q;
  assign o_req1_TREADY = (state_q == S_STREAM) &&  grant_q;
  assign o_crc_TVALID  = crc_vld_q;
  assign o_crc_TDATA   = crc_data_q;
  assign o_res_TVALID  = res_vld_q;
  assign o_res_TDATA   = res_data_q;
  assign o_res_TID     = grant_q;
  assign o_res_TLEN    = len_q;
  assign o_res_TUSER   = flags_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    len_d      = len_q;
    eng_d      = eng_q;
    to_d       = to_q;
    flags_d    = flags_q;
    crc_vld_d  = 1'b0;
    crc_data_d = crc_data_q;
    res_vld_d  = res_vld_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_req0_TVALID || i_req1_TVALID) begin
          grant_d = (i_req0_TVALID && i_req1_TVALID) ? rr_q : i_req1_TVALID;
          len_d   = '0;
          eng_d   = '0;
          to_d    = '0;
          flags_d = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_gvalid) begin
          crc_vld_d  = 1'b1;
          crc_data_d = w_gdata;
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          if (eng_q != C_MIN)    eng_d = w_eng_inc;
          if (w_glast) state_d = (w_eng_inc < C_MIN) ? S_PAD : S_WAIT;
        end else begin
          // A gap terminates the engine frame; later bytes start a new grant.
          flags_d[1] = 1'b1;
          state_d    = (eng_q < C_MIN) ? S_PAD : S_WAIT;
        end
      end
      S_PAD: begin
        crc_vld_d  = 1'b1;
        crc_data_d = '0;
        flags_d[0] = 1'b1;
        eng_d      = w_eng_inc;
        if (w_eng_inc == C_MIN) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_crc_TVALID) begin
          res_data_d = i_crc_TDATA;
          res_vld_d  = 1'b1;
          state_d    = S_RESULT;
        end else if (to_q == C_TO_LAST) begin
          res_data_d = '0;
          flags_d[2] = 1'b1;
          res_vld_d  = 1'b1;
          state_d    = S_RESULT;
        end else begin
          to_d = to_q + C_TW'(1);
        end
      end
      S_RESULT: begin
        if (i_res_TREADY) begin
          res_vld_d = 1'b0;
          rr_d      = ~grant_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_axis_ACLK) begin
    if (i_axis_ARESET) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      len_q      <= '0;
      eng_q      <= '0;
      to_q       <= '0;
      flags_q    <= '0;
      crc_vld_q  <= 1'b0;
      crc_data_q <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      eng_q      <= eng_d;
      to_q       <= to_d;
      flags_q    <= flags_d;
      crc_vld_q  <= crc_vld_d;
      crc_data_q <= crc_data_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sakebi_crc32_arbiter.sv
// ============================================================================
// Module  : tb_sakebi_crc32_arbiter
// Brief   : Directed self-checking bench with a behavioural CRC32 engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sakebi_crc32_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, l0, v1, l1;
  logic [7:0]  d0, d1;
  logic        rdy0, rdy1;
  logic        crc_vld;
  logic [7:0]  crc_dat;
  logic        crc_v;
  logic [31:0] crc_d;
  logic        res_vld;
  logic [31:0] res_dat;
  logic        res_tid;
  logic [15:0] res_len;
  logic [2:0]  res_user;
  logic        res_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sakebi_crc32_arbiter #(
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(64),
    .MIN_BYTES     (4)
  ) dut (
    .i_axis_ACLK  (clk),
    .i_axis_ARESET(rst),
    .i_req0_TVALID(v0),
    .i_req0_TDATA (d0),
    .i_req0_TLAST (l0),
    .o_req0_TREADY(rdy0),
    .i_req1_TVALID(v1),
    .i_req1_TDATA (d1),
    .i_req1_TLAST (l1),
    .o_req1_TREADY(rdy1),
    .o_crc_TVALID (crc_vld),
    .o_crc_TDATA  (crc_dat),
    .i_crc_TVALID (crc_v),
    .i_crc_TDATA  (crc_d),
    .o_res_TVALID (res_vld),
    .o_res_TDATA  (res_dat),
    .o_res_TID    (res_tid),
    .o_res_TLEN   (res_len),
    .o_res_TUSER  (res_user),
    .i_res_TREADY (res_ready)
  );

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_of(input logic [7:0] m[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (m[i]) c = crc_byte(c, m[i]);
    return ~c;
  endfunction

  // Behavioural engine: result appears a few cycles after the frame ends and
  // is held until the next frame's first byte.
  logic [31:0] eng_crc;
  logic        eng_active;
  int          eng_cnt;
  bit          eng_en = 1'b1;
  logic [7:0]  eng_log[$];

  always @(posedge clk) begin
    if (rst) begin
      crc_v <= 1'b0;
      crc_d <= '0;
      eng_active = 1'b0;
      eng_cnt = -1;
    end else if (crc_vld) begin
      if (!eng_active) begin
        eng_active = 1'b1;
        eng_crc = 32'hFFFFFFFF;
        eng_log.delete();
        eng_cnt = -1;
        crc_v <= 1'b0;
      end
      eng_crc = crc_byte(eng_crc, crc_dat);
      eng_log.push_back(crc_dat);
    end else if (eng_active) begin
      eng_active = 1'b0;
      eng_cnt = 4;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
    end else if (eng_cnt == 0) begin
      eng_cnt = -1;
      if (eng_en) begin
        crc_v <= 1'b1;
        crc_d <= ~eng_crc;
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        tid;
    logic [15:0] len;
    logic [2:0]  user;
  } res_t;
  res_t res_log[$];
  int   both_cnt = 0;

  always @(posedge clk) begin
    if (!rst && res_vld && res_ready)
      res_log.push_back('{data: res_dat, tid: res_tid, len: res_len, user: res_user});
    if (rdy0 && rdy1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (i < eng_log.size()) return eng_log[i];
    return 8'hxx;
  endfunction

  function automatic logic rdy(input int id);
    return (id != 0) ? rdy1 : rdy0;
  endfunction

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic l);
    if (id != 0) begin v1 = v; d1 = d; l1 = l; end
    else begin v0 = v; d0 = d; l0 = l; end
  endtask

  task automatic send(input int id, input logic [7:0] msg[$], input bit with_last);
    int budget;
    for (int i = 0; i < msg.size(); i++) begin
      drive(id, 1'b1, msg[i], with_last && (i == msg.size() - 1));
      budget = 0;
      while (!rdy(id) && budget < 300) begin @(negedge clk); budget++; end
      if (!rdy(id)) begin
        check("send_ready", {31'h0, rdy(id)}, 32'd1);
        drive(id, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(negedge clk);
    end
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_vld && n < 500) begin @(negedge clk); n++; end
    check("res_valid", {31'h0, res_vld}, 32'd1);
  endtask

  task automatic take_res(input string tag, input logic [31:0] data, input logic tid,
                          input logic [15:0] len, input logic [2:0] user);
    check({tag, "_data"}, res_dat, data);
    check({tag, "_tid"},  {31'h0, res_tid}, {31'h0, tid});
    check({tag, "_len"},  {16'h0, res_len}, {16'h0, len});
    check({tag, "_user"}, {29'h0, res_user}, {29'h0, user});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_release"}, {31'h0, res_vld}, 32'd0);
  endtask

  initial begin
    logic [7:0] m[$];
    logic [7:0] ma[$], mb[$], ma2[$], mb2[$];
    int n, acc, seen, base;

    rst = 1'b1; res_ready = 1'b0;
    v0 = 1'b0; d0 = '0; l0 = 1'b0; v1 = 1'b0; d1 = '0; l1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_crc_valid", {31'h0, crc_vld}, 32'd0);
    check("rst_tready", {30'h0, rdy1, rdy0}, 32'd0);
    check("rst_res_valid", {31'h0, res_vld}, 32'd0);
    check("rst_res_fields", {res_len, 13'h0, res_user}, 32'd0);
    rst = 1'b0;

    // Check value of "123456789", result held for 10 cycles of back-pressure.
    m = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send(0, m, 1'b1);
    wait_res(n);
    check("std_engine_bytes", eng_log.size(), 32'd9);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'h0, res_vld}, 32'd1);
      check("hold_data", res_dat, 32'hCBF43926);
      @(negedge clk);
    end
    take_res("std", 32'hCBF43926, 1'b0, 16'd9, 3'b000);

    // Short frame from requester 1 gets two zero pad bytes.
    m = {8'h12, 8'h34};
    send(1, m, 1'b1);
    wait_res(n);
    check("pad_engine_bytes", eng_log.size(), 32'd4);
    check("pad_b0", {24'h0, log_at(0)}, 32'h12);
    check("pad_b1", {24'h0, log_at(1)}, 32'h34);
    check("pad_b2", {24'h0, log_at(2)}, 32'h00);
    check("pad_b3", {24'h0, log_at(3)}, 32'h00);
    m = {8'h12, 8'h34, 8'h00, 8'h00};
    take_res("pad", crc_of(m), 1'b1, 16'd2, 3'b001);

    // Requester 0 drops TVALID after 6 bytes, ending the frame.
    m = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(0, m, 1'b0);
    wait_res(n);
    check("gap_engine_bytes", eng_log.size(), 32'd6);
    take_res("gap", crc_of(m), 1'b0, 16'd6, 3'b010);

    // Silent engine: timeout after exactly TIMEOUT_CYCLES in WAIT.
    eng_en = 1'b0;
    m = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send(0, m, 1'b1);
    wait_res(n);
    check("timeout_cycles", n, 32'd64);
    take_res("timeout", 32'h0, 1'b0, 16'd4, 3'b100);
    eng_en = 1'b1;
    m = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send(1, m, 1'b1);
    wait_res(n);
    take_res("after_timeout", crc_of(m), 1'b1, 16'd5, 3'b000);

    // Reset in the middle of a stream.
    v0 = 1'b1; d0 = 8'h55; l0 = 1'b0;
    acc = 0; n = 0;
    while (acc < 2 && n < 100) begin
      if (rdy0) acc++;
      @(negedge clk);
      n++;
    end
    check("abort_accepted", acc, 32'd2);
    check("abort_pre_crc_valid", {31'h0, crc_vld}, 32'd1);
    rst = 1'b1; v0 = 1'b0;
    @(negedge clk);
    check("abort_crc", {23'h0, crc_vld, crc_dat}, 32'd0);
    check("abort_tready", {30'h0, rdy1, rdy0}, 32'd0);
    check("abort_res_data", res_dat, 32'd0);
    check("abort_res_misc", {11'h0, res_vld, res_tid, res_len, res_user}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (res_vld) seen = 1;
    end
    check("abort_no_result", seen, 32'd0);

    // Both requesters contend right after reset: expect 0,1,0,1.
    ma  = {8'h10, 8'h11, 8'h12, 8'h13};
    mb  = {8'h20, 8'h21, 8'h22, 8'h23};
    ma2 = {8'h30, 8'h31, 8'h32, 8'h33};
    mb2 = {8'h40, 8'h41, 8'h42, 8'h43};
    base = res_log.size();
    res_ready = 1'b1;
    fork
      begin send(0, ma, 1'b1); send(0, ma2, 1'b1); end
      begin send(1, mb, 1'b1); send(1, mb2, 1'b1); end
    join
    n = 0;
    while (res_log.size() < base + 4 && n < 500) begin @(negedge clk); n++; end
    res_ready = 1'b0;
    check("rr_count", res_log.size() - base, 32'd4);
    if (res_log.size() >= base + 4) begin
      check("rr_tid0", {31'h0, res_log[base].tid},     32'd0);
      check("rr_tid1", {31'h0, res_log[base + 1].tid}, 32'd1);
      check("rr_tid2", {31'h0, res_log[base + 2].tid}, 32'd0);
      check("rr_tid3", {31'h0, res_log[base + 3].tid}, 32'd1);
      check("rr_data0", res_log[base].data,     crc_of(ma));
      check("rr_data1", res_log[base + 1].data, crc_of(mb));
      check("rr_data2", res_log[base + 2].data, crc_of(ma2));
      check("rr_data3", res_log[base + 3].data, crc_of(mb2));
      check("rr_len_user", {res_log[base + 3].len, 13'h0, res_log[base + 3].user}, {16'd4, 16'h0});
    end
    check("rr_tready_exclusive", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sakebi_crc32_arbiter.md
# sakebi_crc32_arbiter

- Shares one `sakebi_crc32_wrapper` CRC32 engine between two frame requesters (e.g. the TX FCS path and the RX check path).
- Grants whole frames round-robin and streams the granted frame's bytes contiguously into the engine.
- Pads frames shorter than 4 bytes, waits for the engine result with a timeout, and returns the CRC with requester ID, byte length and error flags on a ready/valid result port.

## Interface
- `DATA_WIDTH`, 8: byte lane width; engine and requester data width.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in WAIT before the frame is abandoned.
- `MIN_BYTES`, 4: engine minimum frame length; shorter frames are zero-padded.
- `i_axis_ACLK` in 1: single clock.
- `i_axis_ARESET` in 1: reset, synchronous, active-high.
- `i_req0_TVALID` / `i_req1_TVALID` in 1: requester byte valid.
- `i_req0_TDATA` / `i_req1_TDATA` in DATA_WIDTH: requester byte.
- `i_req0_TLAST` / `i_req1_TLAST` in 1: last byte of frame.
- `o_req0_TREADY` / `o_req1_TREADY` out 1: byte accepted when TVALID&&TREADY.
- `o_crc_TVALID` out 1, `o_crc_TDATA` out DATA_WIDTH: engine input stream, registered.
- `i_crc_TVALID` in 1, `i_crc_TDATA` in 32: engine result (level, held until the engine's next frame starts).
- `o_res_TVALID` out 1, `o_res_TDATA` out 32: CRC result.
- `o_res_TID` out 1: requester served.
- `o_res_TLEN` out 16: requester bytes accepted; saturates at 0xFFFF.
- `o_res_TUSER` out 3: error flags. Bit 0 = short frame padded, bit 1 = TVALID gap mid-frame, bit 2 = timeout.
- `i_res_TREADY` in 1: result consumer ready.

## Operation
- States:
  - IDLE: `o_crc_TVALID`=0. If any `i_reqN_TVALID`, grant by round-robin pointer `rr`: requester `rr` wins ties, otherwise the sole requester wins. Latch grant and clear count/flags, then go to STREAM.
  - STREAM: `o_reqG_TREADY`=1 (combinational from state and grant; the other TREADY is 0). Each accepted byte is registered to `o_crc_TDATA` with `o_crc_TVALID`=1, and the count increments.
    - Accepted byte with TLAST: if count+1 < MIN_BYTES go to PAD, else go to WAIT.
    - Granted TVALID low (gap): set TUSER[1] and drive `o_crc_TVALID`=0, which ends the engine frame. Go to PAD if count < MIN_BYTES, else WAIT. Bytes still offered after the gap belong to the next grant.
  - PAD: drive `o_crc_TDATA`=0 and `o_crc_TVALID`=1 for MIN_BYTES−count cycles. Set TUSER[0]. Go to WAIT. TREADY is 0.
  - WAIT: `o_crc_TVALID`=0. The timeout counter increments each cycle.
    - When `i_crc_TVALID`=1: capture `i_crc_TDATA`, go to RESULT.
    - When the counter reaches TIMEOUT_CYCLES: `o_res_TDATA`=0, set TUSER[2], go to RESULT.
  - RESULT: `o_res_TVALID`=1, all result fields stable. When `i_res_TREADY`=1: set `rr`=~grant, go to IDLE.
- The engine has no backpressure. The arbiter guarantees it sees contiguous bytes and at least one `o_crc_TVALID`=0 cycle between frames (WAIT/IDLE).
- `o_res_TLEN` counts requester bytes only, never pad bytes.
- Reset: state IDLE, `rr`=0, all outputs 0, counters 0. Reset mid-frame abandons the frame; no result is emitted.

## Timing
- Request to first TREADY: 2 cycles (IDLE grant cycle, then STREAM).
- Accepted byte to `o_crc_TVALID`/`o_crc_TDATA`: 1 cycle.
- Engine result to `o_res_TVALID`: 1 cycle. The engine's own latency is 4 zero-flush cycles plus 1 after the last byte; the WAIT timeout covers it.
- Result handshake to next grant: IDLE adds 1 cycle. Minimum frame-to-frame gap on the engine is 3 cycles.
- Back-to-back requests alternate 0,1,0,1… while both are asserted. A single active requester is served every frame.
- `o_res_TVALID` holds until `i_res_TREADY`. No new grant is made while a result is pending.

## Test plan
- Requester 0 sends ASCII "123456789" contiguously with TLAST on "9", using the real engine.
  - Required: `o_res_TDATA`=0xCBF43926, TID=0, TLEN=9, TUSER=0.
- Both requesters assert TVALID in the same cycle after reset.
  - Required: req0 is served first, then req1.
  - Repeating the pair gives order 0,1,0,1. TREADY is never high on both ports in the same cycle.
- Requester 1 sends 2 bytes {0x12,0x34} with TLAST.
  - Required: engine sees 0x12,0x34,0x00,0x00; TLEN=2; TUSER=3'b001.
- Requester 0 drops TVALID for one cycle after 6 bytes.
  - Required: the engine frame ends; result has TUSER[1]=1 and TLEN=6.
- Engine model never raises `i_crc_TVALID`.
  - Required: after TIMEOUT_CYCLES in WAIT, result TDATA=0, TUSER[2]=1. The arbiter then serves the next request normally.
- Hold `i_res_TREADY`=0 for 10 cycles while the result is valid, and pulse `i_axis_ARESET` during STREAM in a separate run.
  - Required: the result stays stable for all 10 cycles.
  - Required: reset returns all outputs to 0 the next cycle, and no result is emitted for the aborted frame.
